pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Central pipeline controller for the 5-stage core. Priority-encodes per-stage stall requests into
//  the 6-bit stall vector consumed by pc_reg and every pipeline register (including the IF/ID register),
//  sequences multi-cycle EX ops (div/mul) with a timeout, and issues one-shot flushes with redirect PC.
//  Stall bit map: [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb; 1 = `Stop.
// PARAMETERS
//  MC_TIMEOUT  64  max cycles in MC_WAIT before forced abort (>=2)
//  CNT_W       16  width of stall-cycle statistics counter
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   reset, asynchronous, active-low (0 = reset)
//  stallreq_if  in   1   fetch bus not ready
//  stallreq_id  in   1   load-use hazard in ID
//  stallreq_ex  in   1   single-cycle EX hazard
//  stallreq_mem in   1   data bus not ready
//  mc_start     in   1   EX begins a multi-cycle op (1-cycle pulse)
//  mc_done      in   1   multi-cycle unit result valid (1-cycle pulse)
//  flush_req    in   1   exception/eret redirect request (level, may be held)
//  flush_pc     in   32  redirect target
//  cnt_clr      in   1   synchronous clear of stall_cnt
//  stall        out  6   stall vector
//  flush        out  1   flush all pipeline registers (1-cycle pulse)
//  new_pc       out  32  redirect target, valid while flush=1, else 0
//  mc_abort     out  1   1-cycle pulse: multi-cycle unit must cancel
//  mc_err       out  1   1-cycle pulse: abort was caused by timeout
//  stall_cnt    out  CNT_W  saturating count of cycles with stall!=0
// BEHAVIOUR
//  - Reset (rst=0, async): state=RUN, mc_cnt=0, stall_cnt=0; stall/flush/new_pc/mc_abort/mc_err forced 0.
//  - Base encode (combinational, same cycle): mem->6'b011111, ex->6'b001111, id->6'b000111,
//    if->6'b000011, none->6'b000000; highest set request wins.
//  - States RUN, MC_WAIT, FLUSH_HOLD (registered, 2-bit).
//  - RUN: stall=base. flush_req=1 -> flush=1, new_pc=flush_pc, stall=0 this cycle, next FLUSH_HOLD
//    (flush beats mc_start and all stalls). Else mc_start=1 -> next MC_WAIT, mc_cnt<=0.
//  - MC_WAIT: stall = base | 6'b001111. mc_done=1 -> stall=base this cycle (EX result advances), next RUN.
//    Else mc_cnt<=mc_cnt+1; when mc_cnt==MC_TIMEOUT-1 and no mc_done -> mc_abort=1, mc_err=1,
//    stall=base, next RUN. flush_req=1 (priority over mc_done and timeout) -> flush=1, new_pc=flush_pc,
//    mc_abort=1, mc_err=0, stall=0, next FLUSH_HOLD.
//  - FLUSH_HOLD: flush=0 even if flush_req still high (one pulse per request); stall=base; mc_start
//    ignored. flush_req=0 -> next RUN. A new request needs flush_req low for >=1 cycle.
//  - stall_cnt: +1 each cycle stall!=0 (the value driven that cycle); saturates at all-ones;
//    cnt_clr=1 -> 0 next cycle (clear wins over increment).
//  - mc_start in MC_WAIT ignored; mc_done outside MC_WAIT ignored.
//  - Reset mid-MC_WAIT: returns to RUN with no mc_abort pulse; downstream units reset themselves.
//  - All outputs except stall_cnt are combinational from state + inputs; no added latency.
// STRUCTURE
//  - define.v: `Stop/`NoStop, STALL_* encodings, PCTRL_RUN/MC_WAIT/FLUSH_HOLD state codes.
//  - Sub-module stall_enc: pure priority encoder (4 requests -> 6-bit vector), instanced once.
//  - pipe_ctrl holds FSM, mc_cnt ($clog2(MC_TIMEOUT) bits), stall_cnt, output muxing.
// TESTING
//  - Reset: rst=0 with all requests=1 -> stall=0, flush=0, stall_cnt=0; release -> stall=6'b011111.
//  - Priority: id=1,ex=1 -> 6'b001111; add mem=1 -> 6'b011111; only if=1 -> 6'b000011.
//  - Multi-cycle: mc_start, mc_done 10 cycles later -> stall=6'b001111 for 10 cycles, 0 on done cycle.
//  - Timeout (MC_TIMEOUT=8): mc_start, no done -> mc_abort=mc_err=1 on 8th MC_WAIT cycle, then RUN.
//  - Flush: flush_req held 5 cycles, flush_pc=32'hBFC00380 -> one flush pulse, new_pc matches,
//    second pulse only after flush_req low then high; flush during MC_WAIT -> mc_abort=1, mc_err=0.
//  - stall_cnt: CNT_W=4, 20 stalled cycles -> 4'hF; cnt_clr with stall active -> 0 next cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stop/no-stop levels,
// stall vector encodings and controller state codes.
package pipe_ctrl_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Stall vector bit map: [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb.
    // A stalled stage also freezes every stage upstream of it.
    localparam logic [5:0] STALL_NONE = {6{NO_STOP}};
    localparam logic [5:0] STALL_IF   = {{4{NO_STOP}}, {2{STOP}}};
    localparam logic [5:0] STALL_ID   = {{3{NO_STOP}}, {3{STOP}}};
    localparam logic [5:0] STALL_EX   = {{2{NO_STOP}}, {4{STOP}}};
    localparam logic [5:0] STALL_MEM  = {NO_STOP, {5{STOP}}};

    typedef enum logic [1:0] {
        PCTRL_RUN        = 2'd0,
        PCTRL_MC_WAIT    = 2'd1,
        PCTRL_FLUSH_HOLD = 2'd2
    } pctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side view of the controller: stall requests, multi-cycle
// handshake, flush request and the resulting control outputs.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             stallreq_if;
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             stallreq_mem;
    logic             mc_start;
    logic             mc_done;
    logic             flush_req;
    logic [31:0]      flush_pc;
    logic             cnt_clr;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             mc_abort;
    logic             mc_err;
    logic [CNT_W-1:0] stall_cnt;

    // Pipeline stages drive requests and consume control.
    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output mc_start, mc_done, flush_req, flush_pc, cnt_clr,
        input  stall, flush, new_pc, mc_abort, mc_err, stall_cnt
    );

    // The controller consumes requests and drives control.
    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  mc_start, mc_done, flush_req, flush_pc, cnt_clr,
        output stall, flush, new_pc, mc_abort, mc_err, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_stall_enc.sv
// Priority encoder: the deepest stalling stage wins and freezes everything
// upstream of it.
module pipe_ctrl_stall_enc
    import pipe_ctrl_pkg::*;
(
    input  logic       req_if,
    input  logic       req_id,
    input  logic       req_ex,
    input  logic       req_mem,
    output logic [5:0] stall
);

    // Highest (deepest) request selects the stall pattern.
    always_comb begin
        if (req_mem)     stall = STALL_MEM;
        else if (req_ex) stall = STALL_EX;
        else if (req_id) stall = STALL_ID;
        else if (req_if) stall = STALL_IF;
        else             stall = STALL_NONE;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall encoding, multi-cycle EX sequencing
// with timeout abort, one-shot flush with redirect PC, stall statistics.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);

    localparam int MC_W = $clog2(MC_TIMEOUT);
    localparam logic [MC_W-1:0] MC_LAST = MC_W'(MC_TIMEOUT - 1);

    pctrl_state_e     state_q, state_d;
    logic [MC_W-1:0]  mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [5:0]  base_stall;
    logic [5:0]  stall_v;
    logic        flush_v;
    logic [31:0] new_pc_v;
    logic        mc_abort_v;
    logic        mc_err_v;

    pipe_ctrl_stall_enc u_stall_enc (
        .req_if  (bus.stallreq_if),
        .req_id  (bus.stallreq_id),
        .req_ex  (bus.stallreq_ex),
        .req_mem (bus.stallreq_mem),
        .stall   (base_stall)
    );

    // Next-state and combinational outputs from current state and inputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d    = state_q;
        mc_cnt_d   = mc_cnt_q;
        stall_v    = base_stall;
        flush_v    = 1'b0;
        new_pc_v   = 32'h0;
        mc_abort_v = 1'b0;
        mc_err_v   = 1'b0;
        unique case (state_q)
            PCTRL_RUN: begin
                if (bus.flush_req) begin
                    flush_v  = 1'b1;
                    new_pc_v = bus.flush_pc;
                    stall_v  = STALL_NONE;
                    state_d  = PCTRL_FLUSH_HOLD;
                end else if (bus.mc_start) begin
                    state_d  = PCTRL_MC_WAIT;
                    mc_cnt_d = '0;
                end
            end
            PCTRL_MC_WAIT: begin
                if (bus.flush_req) begin
                    // Redirect kills the in-flight op; not a timeout.
                    flush_v    = 1'b1;
                    new_pc_v   = bus.flush_pc;
                    mc_abort_v = 1'b1;
                    stall_v    = STALL_NONE;
                    state_d    = PCTRL_FLUSH_HOLD;
                end else if (bus.mc_done) begin
                    // Result ready: release EX this cycle.
                    state_d = PCTRL_RUN;
                end else if (mc_cnt_q == MC_LAST) begin
                    mc_abort_v = 1'b1;
                    mc_err_v   = 1'b1;
                    state_d    = PCTRL_RUN;
                end else begin
                    stall_v  = base_stall | STALL_EX;
                    mc_cnt_d = mc_cnt_q + 1'b1;
                end
            end
            PCTRL_FLUSH_HOLD: begin
                // One pulse per request: wait for flush_req to drop.
                if (!bus.flush_req) state_d = PCTRL_RUN;
            end
            default: state_d = PCTRL_RUN;
        endcase
        if (!rst) begin
            stall_v    = STALL_NONE;
            flush_v    = 1'b0;
            new_pc_v   = 32'h0;
            mc_abort_v = 1'b0;
            mc_err_v   = 1'b0;
        end
    end

    // Saturating count of stalled cycles; clear has priority.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.cnt_clr)
            stall_cnt_d = '0;
        else if ((stall_v != STALL_NONE) && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= PCTRL_RUN;
            mc_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall     = stall_v;
    assign bus.flush     = flush_v;
    assign bus.new_pc    = new_pc_v;
    assign bus.mc_abort  = mc_abort_v;
    assign bus.mc_err    = mc_err_v;
    assign bus.stall_cnt = stall_cnt_q;

endmodule
